// File: rtl/cf_fft_1024_8_reorder.sv
// Ping-pong reorder buffer placed after the last FFT butterfly: frames arrive in
// bit-reversed index order and leave in natural order, one sample per enabled cycle.
module cf_fft_1024_8_reorder #(
    parameter int LOG2N = 10,
    parameter int WIDTH = 16
) (
    input  logic             clock_c,
    input  logic             i5,
    input  logic             i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    input  logic             i4,
    output logic             o1,
    output logic [WIDTH-1:0] o2,
    output logic [WIDTH-1:0] o3,
    output logic             o4
);

    localparam int N  = 1 << LOG2N;
    localparam int DW = 2 * WIDTH;

    // Handshake: there is no backpressure. A sample is taken on i1/i2/i3 at every
    // rising edge with i4=1; o1..o4 change only on such edges and o4 marks a sample.

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        for (int b = 0; b < LOG2N; b++) begin
            r[b] = a[LOG2N-1-b];
        end
        return r;
    endfunction

    logic [DW-1:0] mem [0:2*N-1];

    logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d;
    logic [LOG2N-1:0] rd_cnt_q, rd_cnt_d;
    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    logic             pend_bank_q, pend_bank_d;
    logic             armed_q, armed_d;
    logic             rd_active_q, rd_active_d;
    logic             pend_q, pend_d;
    logic             o1_q, o1_d;
    logic             o4_q, o4_d;
    logic [WIDTH-1:0] o2_q, o2_d;
    logic [WIDTH-1:0] o3_q, o3_d;

    logic             wr_en;
    logic             complete;
    logic [LOG2N-1:0] wr_idx;
    logic [LOG2N:0]   wr_addr;
    logic [LOG2N:0]   rd_addr;
    logic [DW-1:0]    rd_word;

    assign wr_addr = {wr_bank_q, bitrev(wr_idx)};
    assign rd_addr = {rd_bank_q, rd_cnt_q};
    assign rd_word = mem[rd_addr];

    always_comb begin
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        pend_bank_d = pend_bank_q;
        armed_d     = armed_q;
        rd_active_d = rd_active_q;
        pend_d      = pend_q;
        o1_d        = o1_q;
        o4_d        = o4_q;
        o2_d        = o2_q;
        o3_d        = o3_q;
        wr_en       = 1'b0;
        complete    = 1'b0;
        wr_idx      = wr_cnt_q;

        if (i4 && !i5) begin
            // A start marker always restarts the frame in the current bank (resync).
            if (i1) begin
                wr_en    = 1'b1;
                wr_idx   = '0;
                wr_cnt_d = LOG2N'(1);
                armed_d  = 1'b1;
            end else if (armed_q) begin
                wr_en    = 1'b1;
                wr_cnt_d = wr_cnt_q + LOG2N'(1);
                if (&wr_cnt_q) begin
                    complete  = 1'b1;
                    wr_bank_d = ~wr_bank_q;
                end
            end

            if (rd_active_q) begin
                o2_d     = rd_word[DW-1:WIDTH];
                o3_d     = rd_word[WIDTH-1:0];
                o4_d     = 1'b1;
                o1_d     = (rd_cnt_q == '0);
                rd_cnt_d = rd_cnt_q + LOG2N'(1);
                if (&rd_cnt_q) begin
                    // Releasing the bank: the newest completed frame wins the handoff.
                    if (complete) begin
                        rd_bank_d = wr_bank_q;
                        pend_d    = 1'b0;
                    end else if (pend_q) begin
                        rd_bank_d = pend_bank_q;
                        pend_d    = 1'b0;
                    end else begin
                        rd_active_d = 1'b0;
                    end
                end else if (complete) begin
                    pend_d      = 1'b1;
                    pend_bank_d = wr_bank_q;
                end
            end else begin
                o1_d = 1'b0;
                o4_d = 1'b0;
                if (complete) begin
                    rd_active_d = 1'b1;
                    rd_cnt_d    = '0;
                    rd_bank_d   = wr_bank_q;
                end
            end
        end
    end

    always_ff @(posedge clock_c) begin
        if (i5) begin
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            pend_bank_q <= 1'b0;
            armed_q     <= 1'b0;
            rd_active_q <= 1'b0;
            pend_q      <= 1'b0;
            o1_q        <= 1'b0;
            o4_q        <= 1'b0;
            o2_q        <= '0;
            o3_q        <= '0;
        end else begin
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            pend_bank_q <= pend_bank_d;
            armed_q     <= armed_d;
            rd_active_q <= rd_active_d;
            pend_q      <= pend_d;
            o1_q        <= o1_d;
            o4_q        <= o4_d;
            o2_q        <= o2_d;
            o3_q        <= o3_d;
        end
    end

    // Buffer contents survive reset; stale data is never read without a new frame.
    always_ff @(posedge clock_c) begin
        if (wr_en) begin
            mem[wr_addr] <= {i2, i3};
        end
    end

    assign o1 = o1_q;
    assign o2 = o2_q;
    assign o3 = o3_q;
    assign o4 = o4_q;

endmodule
